// File: rtl/icache_dm_if.sv
// Fetch/refill bus of the direct-mapped instruction cache.
// The slave modport is the cache; the master modport is the fetch stage
// together with the backing memory.
interface icache_dm_if #(
    parameter int WIDTH = 32
);
    logic             i_req;
    logic [WIDTH-1:0] i_pc;
    logic             i_flush;
    logic             o_stall;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_mem_req;
    logic [WIDTH-1:0] o_mem_addr;
    logic             i_mem_ack;
    logic [WIDTH-1:0] i_mem_data;

    modport slave (
        input  i_req, i_pc, i_flush, i_mem_ack, i_mem_data,
        output o_stall, o_valid, o_data, o_mem_req, o_mem_addr
    );

    modport master (
        output i_req, i_pc, i_flush, i_mem_ack, i_mem_data,
        input  o_stall, o_valid, o_data, o_mem_req, o_mem_addr
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-serial line refill
// and a full, one-line-per-cycle invalidate.
// Optional feature: define ICACHE_STATS_EN to add hit/miss counters.
module icache_dm #(
    parameter int WIDTH      = 32,
    parameter int LOG2_LINES = 6,
    parameter int LOG2_WORDS = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    icache_dm_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
`endif
);
    localparam int LINES  = 1 << LOG2_LINES;
    localparam int WORDS  = 1 << LOG2_WORDS;
    localparam int TAG_W  = WIDTH - 2 - LOG2_WORDS - LOG2_LINES;
    localparam int IDX_LO = 2 + LOG2_WORDS;
    localparam int TAG_LO = IDX_LO + LOG2_LINES;
    localparam logic [LOG2_WORDS-1:0] WCNT_LAST = '1;
    localparam logic [LOG2_LINES-1:0] FCNT_LAST = '1;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, FILLDONE, FLUSH} state_t;

    state_t                 state, state_nxt;
    logic [LINES-1:0]       valid;
    logic [LOG2_WORDS-1:0]  wcnt;
    logic [LOG2_LINES-1:0]  fcnt;
    logic                   flush_pending;
    logic [WIDTH-1:2]       req_pc;

    // Arrays hold data only; line validity lives in the valid vector.
    logic [WIDTH-1:0]       data_mem [LINES*WORDS];
    logic [TAG_W-1:0]       tag_mem  [LINES];

    logic [LOG2_LINES-1:0]  idx;
    logic [LOG2_WORDS-1:0]  off;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic [WIDTH-1:0]       rd_word;
    logic                   stall;
    logic                   accept;
    logic                   fill_wr;
    logic                   fill_last;
    logic                   valid_o;
    logic [WIDTH-1:0]       data_o;
    logic                   mem_req_o;
    logic [WIDTH-1:0]       mem_addr_o;
    logic                   pc_unused;

    assign idx       = req_pc[TAG_LO-1:IDX_LO];
    assign off       = req_pc[IDX_LO-1:2];
    assign tag       = req_pc[WIDTH-1:TAG_LO];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    assign rd_word   = data_mem[{idx, off}];
    assign stall     = (state != IDLE) | bus.i_flush | flush_pending;
    assign accept    = bus.i_req & ~stall;
    assign fill_wr   = (state == REFILL) & bus.i_mem_ack;
    assign fill_last = fill_wr & (wcnt == WCNT_LAST);
    assign pc_unused = ^bus.i_pc[1:0];

    assign bus.o_stall    = stall;
    assign bus.o_valid    = valid_o;
    assign bus.o_data     = data_o;
    assign bus.o_mem_req  = mem_req_o;
    assign bus.o_mem_addr = mem_addr_o;

    // State register; reset drops any refill in flight immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state and combinational outputs; results are zero unless valid.
    always_comb begin
        state_nxt  = state;
        valid_o    = 1'b0;
        data_o     = '0;
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        case (state)
            IDLE: begin
                if (bus.i_flush || flush_pending) state_nxt = FLUSH;
                else if (bus.i_req)               state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    valid_o   = 1'b1;
                    data_o    = rd_word;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_pc[WIDTH-1:IDX_LO], wcnt, 2'b00};
                if (fill_last) state_nxt = FILLDONE;
            end
            FILLDONE: begin
                valid_o   = 1'b1;
                data_o    = rd_word;
                state_nxt = IDLE;
            end
            FLUSH: begin
                if (fcnt == FCNT_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid bits, fill/flush counters and the deferred-flush flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid         <= '0;
            wcnt          <= '0;
            fcnt          <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (fill_wr) wcnt <= wcnt + 1'b1;
            if (fill_last) valid[idx] <= 1'b1;
            if (state == FLUSH) begin
                valid[fcnt]   <= 1'b0;
                fcnt          <= fcnt + 1'b1;
                flush_pending <= 1'b0;
            end else if (state != IDLE && bus.i_flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // Request address and line storage; contents are not reset.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && accept) req_pc <= bus.i_pc[WIDTH-1:2];
        if (fill_wr) data_mem[{idx, wcnt}] <= bus.i_mem_data;
        if (fill_last) tag_mem[idx] <= tag;
    end

`ifdef ICACHE_STATS_EN
    // Lookup outcome counters; they survive flushes and wrap freely.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) o_hit_cnt  <= o_hit_cnt + 1'b1;
            else     o_miss_cnt <= o_miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a memory responder with adjustable ack
// spacing, a scoreboard queue of expected fetch words, and latency/stall
// checks for hits, misses, flush and mid-refill reset.
module tb_icache_dm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   gap = 1;
    int   model_hits = 0;
    int   model_misses = 0;
    logic [31:0] sb[$];
    logic [31:0] acked[$];

    icache_dm_if #(.WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
    icache_dm dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus),
                   .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt));
`else
    icache_dm dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
`endif

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory side: ack every gap-th cycle of an active refill.
    initial begin
        int gcnt;
        gcnt = 0;
        bus.i_mem_ack  = 1'b0;
        bus.i_mem_data = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !bus.o_mem_req) begin
                bus.i_mem_ack = 1'b0;
                gcnt = 0;
            end else if (gcnt == gap - 1) begin
                bus.i_mem_ack = 1'b1;
                gcnt = 0;
            end else begin
                bus.i_mem_ack = 1'b0;
                gcnt++;
            end
            bus.i_mem_data = bus.i_mem_ack ? mem_word(bus.o_mem_addr) : 32'hBAD0_BAD0;
        end
    end

    // Record each address whose ack the cache will consume at the next edge.
    initial forever begin
        @(negedge clk);
        if (bus.i_mem_ack && bus.o_mem_req) acked.push_back(bus.o_mem_addr);
    end

    task automatic fetch(input logic [31:0] pc, input bit exp_hit, input int exp_lat,
                         input int exp_wait, input string tag);
        int waits, lat;
        bit seen, memreq;
        logic [31:0] exp;
        waits = 0; lat = 0; seen = 0; memreq = 0;
        @(posedge clk); #1;
        bus.i_req = 1'b1;
        bus.i_pc  = pc;
        @(negedge clk);
        while (bus.o_stall && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        bus.i_pc  = pc ^ 32'h0000_FFF0;
        sb.push_back(mem_word({pc[31:2], 2'b00}));
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.o_mem_req) memreq = 1'b1;
            if (bus.o_valid) seen = 1'b1;
        end
        chk({tag, "_stall_cycles"}, waits, exp_wait);
        chk({tag, "_valid_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            exp = sb.pop_front();
            chk({tag, "_data"}, bus.o_data, exp);
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_mem_req"}, {31'b0, memreq}, {31'b0, !exp_hit});
        if (exp_hit) model_hits++;
        else         model_misses++;
    endtask

    initial begin
        int cnt, base;
        logic [31:0] exp_addr;
        bus.i_req   = 1'b0;
        bus.i_pc    = '0;
        bus.i_flush = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid",    {31'b0, bus.o_valid},   32'd0);
        chk("rst_mem_req",  {31'b0, bus.o_mem_req}, 32'd0);
        chk("rst_mem_addr", bus.o_mem_addr,         32'd0);
        chk("rst_data",     bus.o_data,             32'd0);
        chk("rst_stall",    {31'b0, bus.o_stall},   32'd0);
        rst_n = 1'b1;

        // First miss: refill addresses walk the line in order.
        acked.delete();
        fetch(32'h100, 1'b0, 6, 0, "miss100");
        chk("fill_words", acked.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'h100 + 32'(4 * i);
            chk($sformatf("fill_addr%0d", i), (i < acked.size()) ? acked[i] : 32'hFFFF_FFFF, exp_addr);
        end
        fetch(32'h104, 1'b1, 1, 0, "hit104");
        fetch(32'h10C, 1'b1, 1, 0, "hit10C");

        // Same index, different tag evicts the line.
        fetch(32'h500, 1'b0, 6, 0, "miss500");
        fetch(32'h100, 1'b0, 6, 0, "remiss100");
        fetch(32'h108, 1'b1, 1, 0, "hit108");
        fetch(32'h140, 1'b0, 6, 0, "miss140");
        fetch(32'h144, 1'b1, 1, 0, "hit144");

        // Flush during a slow refill: fill completes, then 64 flush cycles.
        gap = 3;
        fork
            fetch(32'h2000, 1'b0, 14, 0, "slowfill");
            begin
                repeat (4) @(posedge clk);
                #1 bus.i_flush = 1'b1;
                @(posedge clk);
                #1 bus.i_flush = 1'b0;
            end
        join
        gap = 1;
        fetch(32'h140, 1'b0, 6, 65, "postflush140");
        fetch(32'h100, 1'b0, 6, 0, "postflush100");

        // Reset after the second ack of a refill.
        @(posedge clk); #1;
        bus.i_req = 1'b1;
        bus.i_pc  = 32'h300;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        base = acked.size();
        cnt = 0;
        while (acked.size() < base + 2 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_two_acks", acked.size() - base, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", {31'b0, bus.o_mem_req}, 32'd0);
        chk("midrst_valid",   {31'b0, bus.o_valid},   32'd0);
        chk("midrst_stall",   {31'b0, bus.o_stall},   32'd0);
        model_hits = 0;
        model_misses = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        acked.delete();
        fetch(32'h300, 1'b0, 6, 0, "postrst300");
        chk("postrst_first_addr", (acked.size() > 0) ? acked[0] : 32'hFFFF_FFFF, 32'h300);
        fetch(32'h140, 1'b0, 6, 0, "postrst140");

        // Counter sequence: 0x40 lands on index 4, so it misses.
        fetch(32'h0,  1'b0, 6, 0, "seq0");
        fetch(32'h4,  1'b1, 1, 0, "seq4");
        fetch(32'h0,  1'b1, 1, 0, "seq0b");
        fetch(32'h40, 1'b0, 6, 0, "seq40");
`ifdef ICACHE_STATS_EN
        #1;
        chk("hit_cnt",  hit_cnt,  32'(model_hits));
        chk("miss_cnt", miss_cnt, 32'(model_misses));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
